// File: rtl/bch_chien_sched_pkg.sv
// Shared types and sizing helpers for the two-requester Chien search scheduler.
package bch_chien_sched_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} sched_state_e;

  function automatic int unsigned sigma_sz(input int unsigned m, input int unsigned t);
    return (t + 1) * m;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned t);
    return $clog2(t + 1) + 1;
  endfunction

  function automatic int unsigned chien_cycles(input int unsigned data_bits,
                                               input int unsigned bits);
    return (data_bits + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/bch_chien_sched_root_count.sv
// Registered popcount accumulator for Chien roots; synchronous clear, saturates at all-ones.
module bch_chien_root_count #(
  parameter int unsigned Bits = 1,
  parameter int unsigned Cw   = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [Bits-1:0] bits_i,
  output logic [Cw-1:0]   count_o
);

  localparam int unsigned SumW = Cw + $clog2(Bits + 1);

  logic [Cw-1:0]   count_q, count_d;
  logic [SumW-1:0] pop, sum;

  always_comb begin
    pop = '0;
    for (int unsigned b = 0; b < Bits; b++) pop = pop + SumW'(bits_i[b]);
    sum     = SumW'(count_q) + pop;
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (sum > SumW'({Cw{1'b1}})) ? {Cw{1'b1}} : sum[Cw-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bch_chien_sched.sv
// Round-robin sharing of one Chien search engine between two key-equation solvers.
// Optional watchdog: define BCH_CHIEN_SCHED_TIMEOUT_EN to add it and the timeout_o port.
module bch_chien_sched
  import bch_chien_sched_pkg::*;
#(
  parameter int unsigned M         = 8,
  parameter int unsigned T         = 3,
  parameter int unsigned BITS      = 1,
  parameter int unsigned DATA_BITS = 128,
  localparam int unsigned SigmaSz  = sigma_sz(M, T),
  localparam int unsigned Cw       = cnt_width(T),
  localparam int unsigned Cycles   = chien_cycles(DATA_BITS, BITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*SigmaSz-1:0] req_sigma_i,
  input  logic [2*Cw-1:0]      req_deg_i,
  input  logic                 chien_ready_i,
  output logic                 chien_start_o,
  output logic [SigmaSz-1:0]   chien_sigma_o,
  input  logic                 chien_valid_i,
  input  logic                 chien_last_i,
  input  logic [BITS-1:0]      chien_root_i,
  output logic                 err_valid_o,
  output logic                 err_owner_o,
  output logic [BITS-1:0]      err_bits_o,
  output logic                 done_o,
  output logic                 done_fail_o,
`ifdef BCH_CHIEN_SCHED_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic [Cw-1:0]        err_count_o
);

  sched_state_e state_q, state_d;

  logic               rr_q;
  logic               owner_q;
  logic [SigmaSz-1:0] sigma_q;
  logic [Cw-1:0]      deg_q;
  logic               err_valid_q;
  logic [BITS-1:0]    err_bits_q;
  logic               last_q;
  logic               grant, winner, run_valid;
  logic               wd_fire, to_q;

  assign grant     = (state_q == StIdle) && chien_ready_i && (|req_valid_i);
  // Contention goes to the pointer side; a lone requester always wins.
  assign winner    = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
  assign run_valid = (state_q == StRun) && chien_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant) state_d = StLoad;
      StLoad: state_d = (deg_q == '0) ? StDone : StRun;
      StRun:  if (last_q || wd_fire) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o   = 2'b00;
    chien_start_o = 1'b0;
    done_o        = 1'b0;
    done_fail_o   = 1'b0;
    if (grant) req_ready_o = winner ? 2'b10 : 2'b01;
    if (state_q == StLoad) chien_start_o = (deg_q != '0);
    if (state_q == StDone) begin
      done_o      = 1'b1;
      done_fail_o = (err_count_o != deg_q) || to_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      sigma_q     <= '0;
      deg_q       <= '0;
      err_valid_q <= 1'b0;
      err_bits_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      if (grant) begin
        rr_q    <= ~winner;
        owner_q <= winner;
        sigma_q <= winner ? req_sigma_i[2*SigmaSz-1:SigmaSz] : req_sigma_i[SigmaSz-1:0];
        deg_q   <= winner ? req_deg_i[2*Cw-1:Cw] : req_deg_i[Cw-1:0];
      end
      err_valid_q <= run_valid;
      err_bits_q  <= run_valid ? chien_root_i : '0;
      // Delaying last by one cycle puts done strictly after the final err_valid.
      last_q      <= run_valid && chien_last_i;
    end
  end

  bch_chien_root_count #(
    .Bits (BITS),
    .Cw   (Cw)
  ) u_root_count (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (grant),
    .en_i    (run_valid),
    .bits_i  (chien_root_i),
    .count_o (err_count_o)
  );

`ifdef BCH_CHIEN_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(Cycles + 4) + 1;
  logic [WdW-1:0] wd_q;

  // Fires so that DONE lands CYCLES+4 cycles after the start pulse.
  assign wd_fire   = (state_q == StRun) && (wd_q == WdW'(Cycles + 2));
  assign timeout_o = done_o && to_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (chien_start_o)         wd_q <= '0;
      else if (state_q == StRun) wd_q <= wd_q + 1'b1;
      if (grant)                 to_q <= 1'b0;
      else if (wd_fire)          to_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign to_q    = 1'b0;
`endif

  assign chien_sigma_o = sigma_q;
  assign err_valid_o   = err_valid_q;
  assign err_bits_o    = err_bits_q;
  assign err_owner_o   = owner_q;

endmodule

// File: tb/tb_bch_chien_sched.sv
// Directed/randomised bench for bch_chien_sched with a behavioural engine and scheduler model.
module tb_bch_chien_sched;

  localparam int Cycles = 128;
  localparam int CntMax = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_sigma;
  logic [5:0]  req_deg;
  logic        chien_ready, chien_start;
  logic [31:0] chien_sigma;
  logic        chien_valid, chien_last;
  logic [0:0]  chien_root;
  logic        err_valid, err_owner;
  logic [0:0]  err_bits;
  logic        done, done_fail;
  logic [2:0]  err_count;
`ifdef BCH_CHIEN_SCHED_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;
  int rr     = 0;

  always #5 clk = ~clk;

  bch_chien_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_sigma_i   (req_sigma),
    .req_deg_i     (req_deg),
    .chien_ready_i (chien_ready),
    .chien_start_o (chien_start),
    .chien_sigma_o (chien_sigma),
    .chien_valid_i (chien_valid),
    .chien_last_i  (chien_last),
    .chien_root_i  (chien_root),
    .err_valid_o   (err_valid),
    .err_owner_o   (err_owner),
    .err_bits_o    (err_bits),
    .done_o        (done),
    .done_fail_o   (done_fail),
`ifdef BCH_CHIEN_SCHED_TIMEOUT_EN
    .timeout_o     (timeout),
`endif
    .err_count_o   (err_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request/search transaction; rst_at >= 0 pulses reset at that search cycle.
  task automatic job(input logic [1:0] rv, input int d0, input int d1, input int nroots,
                     input int rst_at);
    int win, deg, first_err, n_err, done_t, n_done, stray, exp_cnt;
    logic [31:0] sig0, sig1, sig;
    logic [Cycles-1:0] exp_map, obs_map;
    logic owner_ok, got_fail;
    logic [2:0] got_cnt;
    win  = (rv == 2'b11) ? rr : (rv[1] ? 1 : 0);
    rr   = 1 - win;
    sig0 = $urandom;
    sig1 = $urandom;
    deg  = win ? d1 : d0;
    sig  = win ? sig1 : sig0;
    @(posedge clk); #1;
    req_valid = rv;
    req_sigma = {sig1, sig0};
    req_deg   = {3'(d1), 3'(d0)};
    @(negedge clk);
    check("req_ready_onehot", req_ready, win ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_sigma = ~req_sigma;
    @(negedge clk);
    check("chien_start", chien_start, deg != 0);
    if (deg == 0) begin
      @(negedge clk);
      check("deg0_done", {done, done_fail, err_count}, 5'b10000);
      return;
    end
    check("chien_sigma", chien_sigma, sig);
    exp_map = '0;
    for (int i = 0; i < nroots; i++) begin
      int p;
      do p = $urandom_range(0, Cycles - 1); while (exp_map[p]);
      exp_map[p] = 1'b1;
    end
    first_err = -1; n_err = 0; done_t = -1; n_done = 0; stray = 0;
    obs_map = '0; owner_ok = 1'b1; got_fail = 1'b0; got_cnt = '0;
    for (int t = 0; t < Cycles + 6; t++) begin
      @(posedge clk); #1;
      rst         = (t == rst_at);
      chien_valid = (t < Cycles);
      chien_root  = (t < Cycles) ? exp_map[t] : 1'b0;
      chien_last  = (t == Cycles - 1);
      @(negedge clk);
      if (t == rst_at) begin
        check("reset_clears_outputs", {req_ready, chien_start, chien_sigma, err_valid,
              err_owner, err_bits, done, done_fail, err_count}, '0);
      end else if (rst_at >= 0 && t > rst_at) begin
        if (err_valid || done || chien_start) stray++;
      end else begin
        if (err_valid) begin
          n_err++;
          if (first_err < 0) first_err = t;
          if (t >= 1 && t <= Cycles) obs_map[t-1] = err_bits[0];
          if (err_owner != win[0]) owner_ok = 1'b0;
        end
        if (done) begin
          n_done++;
          done_t   = t;
          got_fail = done_fail;
          got_cnt  = err_count;
        end
      end
    end
    chien_valid = 1'b0; chien_last = 1'b0; chien_root = '0; rst = 1'b0;
    if (rst_at >= 0) begin
      check("post_reset_quiet", stray, 0);
      rr = 0;
      return;
    end
    exp_cnt = (nroots > CntMax) ? CntMax : nroots;
    check("first_err_latency", first_err, 1);
    check("err_valid_count", n_err, Cycles);
    check("root_map", obs_map, exp_map);
    check("err_owner", owner_ok, 1'b1);
    check("done_single", n_done, 1);
    check("done_timing", done_t, Cycles + 1);
    check("err_count", got_cnt, exp_cnt);
    check("done_fail", got_fail, exp_cnt != deg);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_sigma = '0; req_deg = '0;
    chien_ready = 1'b1; chien_valid = 1'b0; chien_last = 1'b0; chien_root = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {req_ready, chien_start, chien_sigma, err_valid, err_owner,
          err_bits, done, done_fail, err_count}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Engine busy: requests wait; stray engine output outside RUN is ignored.
    chien_ready = 1'b0; req_valid = 2'b11; chien_valid = 1'b1; chien_root = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_when_engine_busy", {req_ready, err_valid, done}, '0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; chien_ready = 1'b1; chien_valid = 1'b0; chien_root = '0;

    job(2'b01, 2, 0, 2, -1);
    job(2'b11, 1, 2, 2, -1);
    job(2'b11, 3, 1, 1, -1);
    job(2'b11, 2, 2, 2, -1);
    job(2'b10, 0, 3, 2, -1);
    job(2'b01, 0, 3, 0, -1);
    job(2'b01, 3, 0, 9, -1);
    job(2'b11, 2, 3, 2, 40);
    job(2'b11, 1, 2, 1, -1);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] rv;
      rv = 2'($urandom_range(1, 3));
      job(rv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
